module_alu_issue: RTL

//  Instruction issue/writeback controller that drives the CPU's registered ALU (module_alu).

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/module_regfile.sv | 35 +++
 rtl/module_alu_issue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA constants, instruction field positions, issue FSM encoding and
// immediate sign-extension helpers for the ALU issue controller.
package cpu_pkg;

    localparam int DW    = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 13;
    localparam int RD_MSB    = 12;
    localparam int RD_LSB    = 10;
    localparam int RS_MSB    = 9;
    localparam int RS_LSB    = 7;
    localparam int RT_MSB    = 6;
    localparam int RT_LSB    = 4;
    localparam int IMM7_MSB  = 6;
    localparam int IMM10_MSB = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    function automatic logic [DW-1:0] sext7(input logic [6:0] v);
        return {{(DW-7){v[6]}}, v};
    endfunction

    function automatic logic [DW-1:0] sext10(input logic [9:0] v);
        return {{(DW-10){v[9]}}, v};
    endfunction

endpackage

// File: rtl/module_regfile.sv
// 8x16 register file: two async operand reads plus a debug read, one sync write.
// R0 is hard-wired to zero; reads return the pre-write value during a write cycle.
module module_regfile
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b,
    output logic [DW-1:0] o_dbg_data
);

    logic [DW-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/module_alu_issue.sv
// Single-issue controller for the registered ALU: accept -> ISSUE (T+1) -> WB (T+2).
// instr_ready is high only in IDLE; a held instr_valid simply waits, there is no skid buffer.
module module_alu_issue
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [2:0]    alu_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    output logic          wb_done,
    output logic          illegal,
    output logic          busy,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_rd;
    logic          r_illegal;
    logic [2:0]    r_alu_op;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;

    logic [2:0]    w_op;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_rs;
    logic [AW-1:0] w_rt;
    logic [DW-1:0] w_rs_val;
    logic [DW-1:0] w_rt_val;
    logic [DW-1:0] w_imm7;
    logic [DW-1:0] w_imm10;
    logic          w_accept;
    logic          w_is_alu;
    logic [2:0]    w_alu_op;
    logic [DW-1:0] w_alu_a;
    logic [DW-1:0] w_alu_b;

    assign w_op    = instr[OP_MSB:OP_LSB];
    assign w_rd    = instr[RD_MSB:RD_LSB];
    assign w_rs    = instr[RS_MSB:RS_LSB];
    assign w_rt    = instr[RT_MSB:RT_LSB];
    assign w_imm7  = sext7(instr[IMM7_MSB:0]);
    assign w_imm10 = sext10(instr[IMM10_MSB:0]);

    assign w_accept = instr_valid && (r_state == ST_IDLE);
    assign w_is_alu = (w_op != OP_NOP) && (w_op != OP_RSVD);

    module_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (r_state == ST_WB),
        .i_waddr    (r_rd),
        .i_wdata    (alu_result),
        .i_raddr_a  (w_rs),
        .i_raddr_b  (w_rt),
        .i_dbg_addr (dbg_addr),
        .o_rdata_a  (w_rs_val),
        .o_rdata_b  (w_rt_val),
        .o_dbg_data (dbg_data)
    );

    // Operands are read at the accept edge; nothing else can write the
    // regfile before this instruction's own writeback.
    always_comb begin
        w_alu_op = OP_NOP;
        w_alu_a  = '0;
        w_alu_b  = '0;
        case (w_op)
            OP_ADD, OP_SUB, OP_MUL: begin
                w_alu_op = w_op;
                w_alu_a  = w_rs_val;
                w_alu_b  = w_rt_val;
            end
            OP_ADDI, OP_SUBI: begin
                w_alu_op = w_op;
                w_alu_a  = w_rs_val;
                w_alu_b  = w_imm7;
            end
            OP_LDI: begin
                w_alu_op = OP_ADD;
                w_alu_a  = '0;
                w_alu_b  = w_imm10;
            end
            default: begin
                w_alu_op = OP_NOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = (w_accept && w_is_alu) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: w_state_nxt = ST_WB;
            ST_WB:    w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU drive registers are loaded only on an accept, so they are
    // non-zero exactly during the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd      <= '0;
            r_illegal <= 1'b0;
            r_alu_op  <= OP_NOP;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
        end else begin
            r_illegal <= w_accept && (w_op == OP_RSVD);
            if (w_accept && w_is_alu) begin
                r_rd     <= w_rd;
                r_alu_op <= w_alu_op;
                r_alu_a  <= w_alu_a;
                r_alu_b  <= w_alu_b;
            end else begin
                r_alu_op <= OP_NOP;
                r_alu_a  <= '0;
                r_alu_b  <= '0;
            end
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign wb_done     = (r_state == ST_WB);
    assign illegal     = r_illegal;
    assign alu_opcode  = r_alu_op;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;

endmodule
